// File: rtl/ps2_pkg.sv
// ============================================================================
// Module      : ps2_pkg
// Description : Scancodes, held-key indices and receiver states shared by the
//               PS/2 game-input block.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_W     = 8'h1D;

  typedef enum logic [2:0] {
    KEY_LEFT  = 3'd0,
    KEY_RIGHT = 3'd1,
    KEY_UP    = 3'd2,
    KEY_SPACE = 3'd3,
    KEY_A     = 3'd4,
    KEY_D     = 3'd5,
    KEY_W     = 3'd6
  } key_idx_t;

  localparam int KEY_COUNT = 7;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/ps2_game_input_if.sv
// ============================================================================
// Module      : ps2_game_input_if
// Description : PS/2 pins plus decoded key levels and receiver status.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface ps2_game_input_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       move_left;
  logic       move_right;
  logic       jump;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_dat,
    input  move_left, move_right, jump, rx_byte, rx_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_dat,
    output move_left, move_right, jump, rx_byte, rx_valid, frame_err
  );
endinterface

`default_nettype wire

// File: rtl/ps2_rx.sv
// ============================================================================
// Module      : ps2_rx
// Description : PS/2 frame receiver: pin synchroniser, framing FSM, odd-parity
//               check and mid-frame timeout.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ps2_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       i_ps2_clk,
  input  wire logic       i_ps2_dat,
  output logic [7:0]      o_rx_byte,
  output logic            o_rx_valid,
  output logic            o_frame_err
);
  import ps2_pkg::*;

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] c_to_last = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] c_to_fire = CW'(TIMEOUT_CYCLES - 2);

  logic            r_clk_s1, r_clk_s2, r_clk_h;
  logic            r_dat_s1, r_dat_s2;
  rx_state_t       r_state, w_state_nxt;
  logic [7:0]      r_shift;
  logic [2:0]      r_bit_cnt;
  logic            r_par;
  logic [CW-1:0]   r_to_cnt;
  logic [7:0]      r_rx_byte;
  logic            r_rx_valid, r_frame_err;
  logic            w_fall, w_dat, w_good, w_timeout, w_valid_d, w_err_d;

  assign w_fall    = r_clk_h & ~r_clk_s2;
  assign w_dat     = r_dat_s2;
  assign w_good    = w_dat & (^{r_shift, r_par});
  // A fall in the same cycle keeps the frame alive.
  assign w_timeout = (r_state != RX_IDLE) && !w_fall && (r_to_cnt == c_to_fire);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= RX_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = RX_IDLE;
    end else if (w_fall) begin
      case (r_state)
        RX_IDLE:   if (!w_dat) w_state_nxt = RX_DATA;
        RX_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = RX_PARITY;
        RX_PARITY: w_state_nxt = RX_STOP;
        RX_STOP:   w_state_nxt = RX_IDLE;
        default:   w_state_nxt = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    w_valid_d = (r_state == RX_STOP) && w_fall && w_good;
    w_err_d   = w_timeout ||
                (w_fall && (((r_state == RX_IDLE) && w_dat) ||
                            ((r_state == RX_STOP) && !w_good)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_s1    <= 1'b1;
      r_clk_s2    <= 1'b1;
      r_clk_h     <= 1'b1;
      r_dat_s1    <= 1'b1;
      r_dat_s2    <= 1'b1;
      r_shift     <= 8'h00;
      r_bit_cnt   <= 3'd0;
      r_par       <= 1'b0;
      r_to_cnt    <= '0;
      r_rx_byte   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_clk_s1    <= i_ps2_clk;
      r_clk_s2    <= r_clk_s1;
      r_clk_h     <= r_clk_s2;
      r_dat_s1    <= i_ps2_dat;
      r_dat_s2    <= r_dat_s1;
      r_rx_valid  <= w_valid_d;
      r_frame_err <= w_err_d;
      if (w_valid_d) r_rx_byte <= r_shift;
      if (r_state == RX_IDLE) r_bit_cnt <= 3'd0;
      if (w_fall && (r_state == RX_DATA)) begin
        r_shift   <= {w_dat, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_fall && (r_state == RX_PARITY)) r_par <= w_dat;
      if (w_fall || (r_state == RX_IDLE))   r_to_cnt <= '0;
      else if (r_to_cnt != c_to_last)       r_to_cnt <= r_to_cnt + CW'(1);
    end
  end

  assign o_rx_byte   = r_rx_byte;
  assign o_rx_valid  = r_rx_valid;
  assign o_frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: rtl/ps2_game_input.sv
// ============================================================================
// Module      : ps2_game_input
// Description : PS/2 keyboard to held-key levels (left/right/jump) with E0/F0
//               prefix decoding. Define PS2_WASD_EN to add the A/D/W keys.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ps2_game_input #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  wire logic          clk,
  input  wire logic          rst,
  ps2_game_input_if.slave    bus
);
  import ps2_pkg::*;

  logic [7:0]           w_rx_byte;
  logic                 w_rx_valid, w_frame_err;
  logic                 r_ext, r_brk;
  logic [KEY_COUNT-1:0] r_held;
  logic                 w_hit;
  key_idx_t             w_idx;

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk         (clk),
    .rst         (rst),
    .i_ps2_clk   (bus.ps2_clk),
    .i_ps2_dat   (bus.ps2_dat),
    .o_rx_byte   (w_rx_byte),
    .o_rx_valid  (w_rx_valid),
    .o_frame_err (w_frame_err)
  );

  // Keypad codes share 6B/74/75 with the arrows; only the E0 forms map.
  always_comb begin
    w_hit = 1'b0;
    w_idx = KEY_LEFT;
    if (r_ext) begin
      case (w_rx_byte)
        SC_LEFT:  begin w_hit = 1'b1; w_idx = KEY_LEFT;  end
        SC_RIGHT: begin w_hit = 1'b1; w_idx = KEY_RIGHT; end
        SC_UP:    begin w_hit = 1'b1; w_idx = KEY_UP;    end
        default:  w_hit = 1'b0;
      endcase
    end else begin
      case (w_rx_byte)
        SC_SPACE: begin w_hit = 1'b1; w_idx = KEY_SPACE; end
`ifdef PS2_WASD_EN
        SC_A:     begin w_hit = 1'b1; w_idx = KEY_A;     end
        SC_D:     begin w_hit = 1'b1; w_idx = KEY_D;     end
        SC_W:     begin w_hit = 1'b1; w_idx = KEY_W;     end
`endif
        default:  w_hit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ext  <= 1'b0;
      r_brk  <= 1'b0;
      r_held <= '0;
    end else if (w_frame_err) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_rx_valid) begin
      if (w_rx_byte == SC_EXT) begin
        r_ext <= 1'b1;
      end else if (w_rx_byte == SC_BRK) begin
        r_brk <= 1'b1;
      end else begin
        if (w_hit) r_held[w_idx] <= ~r_brk;
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  assign bus.move_left  = r_held[KEY_LEFT]  | r_held[KEY_A];
  assign bus.move_right = r_held[KEY_RIGHT] | r_held[KEY_D];
  assign bus.jump       = r_held[KEY_UP] | r_held[KEY_SPACE] | r_held[KEY_W];
  assign bus.rx_byte    = w_rx_byte;
  assign bus.rx_valid   = w_rx_valid;
  assign bus.frame_err  = w_frame_err;

endmodule

`default_nettype wire
